// File: rtl/seq_monitor_if.sv
// Sample bus between a 9-state counter and its sequence monitor, plus monitor status.
// Latency: none; wires only.
// Backpressure: none; in_valid qualifies each sample and there is no ready.
interface seq_monitor_if #(
   parameter int ERR_W = 8,
   parameter int LAP_W = 8
);
   // Sample side, driven by the counter or test harness.
   logic             in_valid;
   logic [3:0]       seq_in;
   logic             clear;

   // Status side, driven by the monitor.
   logic             locked;
   logic             err_pulse;
   logic             illegal_pulse;
   logic             lap_pulse;
   logic [ERR_W-1:0] err_count;
   logic [LAP_W-1:0] lap_count;

   // Counter / harness view.
   modport master (
      output in_valid, seq_in, clear,
      input  locked, err_pulse, illegal_pulse, lap_pulse, err_count, lap_count
   );

   // Monitor view.
   modport slave (
      input  in_valid, seq_in, clear,
      output locked, err_pulse, illegal_pulse, lap_pulse, err_count, lap_count
   );
endinterface

// File: rtl/seq_monitor.sv
// Checks the 0,9,A,C,7,D,4,5,6 counter sequence: locks on, flags breaks, counts laps and errors.
// Latency: 1 cycle; every status output is registered on the edge that samples seq_in.
// Backpressure: none; edges with in_valid low are ignored entirely.
module seq_monitor #(
   parameter int LOCK_CNT = 3,
   parameter int ERR_W    = 8,
   parameter int LAP_W    = 8
) (
   input  logic          clk,
   input  logic          reset,
   seq_monitor_if.slave  mon
);

   typedef enum logic [1:0] {
      SEARCH = 2'd0,
      TRACK  = 2'd1,
      LOCKED = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nxt;

   // prev holds the sequence index (0..8) of the last legal sample, not the raw code.
   logic [3:0]       prev;
   logic [3:0]       prev_nxt;
   logic [3:0]       good;
   logic [3:0]       good_nxt;

   logic             legal;
   logic [3:0]       idx;
   logic [3:0]       succ_prev;
   logic             match;
   logic [4:0]       good_inc;
   logic             lock_hit;

   logic             err_nxt;
   logic             illegal_nxt;
   logic             lap_nxt;

   logic             locked_q;
   logic             err_q;
   logic             illegal_q;
   logic             lap_q;
   logic [ERR_W-1:0] err_cnt;
   logic [LAP_W-1:0] lap_cnt;

   // Map the raw 4-bit code to its position in the sequence; the seven unused codes are illegal.
   always_comb begin
      legal = 1'b1;
      idx   = 4'd0;
      case (mon.seq_in)
         4'b0000: idx = 4'd0;
         4'b1001: idx = 4'd1;
         4'b1010: idx = 4'd2;
         4'b1100: idx = 4'd3;
         4'b0111: idx = 4'd4;
         4'b1101: idx = 4'd5;
         4'b0100: idx = 4'd6;
         4'b0101: idx = 4'd7;
         4'b0110: idx = 4'd8;
         default: legal = 1'b0;
      endcase
   end

   // Expected next index wraps 8 -> 0; match implies the sample was legal.
   assign succ_prev = (prev == 4'd8) ? 4'd0 : prev + 4'd1;
   assign match     = legal && (idx == succ_prev);
   // One extra bit so the compare cannot alias when good is at its ceiling.
   assign good_inc  = {1'b0, good} + 5'd1;
   assign lock_hit  = (good_inc == 5'(LOCK_CNT));

   // State register: FSM state plus the tracking context it reasons about.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= SEARCH;
         prev  <= 4'd0;
         good  <= 4'd0;
      end else begin
         state <= state_nxt;
         prev  <= prev_nxt;
         good  <= good_nxt;
      end
   end

   // Next-state logic: illegal codes always fall back to SEARCH, keeping prev untouched.
   always_comb begin
      state_nxt = state;
      prev_nxt  = prev;
      good_nxt  = good;
      if (mon.in_valid) begin
         if (!legal) begin
            state_nxt = SEARCH;
            good_nxt  = 4'd0;
         end else begin
            case (state)
               SEARCH: begin
                  // First legal code only seeds prev; it proves nothing yet.
                  prev_nxt  = idx;
                  good_nxt  = 4'd0;
                  state_nxt = TRACK;
               end
               TRACK: begin
                  prev_nxt = idx;
                  if (match) begin
                     good_nxt = good_inc[3:0];
                     if (lock_hit) begin
                        state_nxt = LOCKED;
                     end
                  end else begin
                     good_nxt = 4'd0;
                  end
               end
               LOCKED: begin
                  prev_nxt = idx;
                  if (!match) begin
                     // Any wrong legal code, including a repeat, drops lock but keeps tracking from it.
                     good_nxt  = 4'd0;
                     state_nxt = TRACK;
                  end
               end
               default: begin
                  state_nxt = SEARCH;
                  good_nxt  = 4'd0;
               end
            endcase
         end
      end
   end

   // Output decode: pulse conditions for this sample, registered below.
   always_comb begin
      err_nxt     = 1'b0;
      illegal_nxt = 1'b0;
      lap_nxt     = 1'b0;
      if (mon.in_valid) begin
         illegal_nxt = !legal;
         if (state == LOCKED) begin
            // An illegal code while locked is one error, not two.
            err_nxt = !match;
            lap_nxt = match && (idx == 4'd0);
         end
      end
   end

   // Status registers: pulses, lock flag and saturating counters; clear beats increment.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         locked_q  <= 1'b0;
         err_q     <= 1'b0;
         illegal_q <= 1'b0;
         lap_q     <= 1'b0;
         err_cnt   <= '0;
         lap_cnt   <= '0;
      end else begin
         locked_q  <= (state_nxt == LOCKED);
         err_q     <= err_nxt;
         illegal_q <= illegal_nxt;
         lap_q     <= lap_nxt;
         if (mon.clear) begin
            err_cnt <= '0;
         end else if (err_nxt && (err_cnt != {ERR_W{1'b1}})) begin
            err_cnt <= err_cnt + 1'b1;
         end
         if (mon.clear) begin
            lap_cnt <= '0;
         end else if (lap_nxt && (lap_cnt != {LAP_W{1'b1}})) begin
            lap_cnt <= lap_cnt + 1'b1;
         end
      end
   end

   assign mon.locked        = locked_q;
   assign mon.err_pulse     = err_q;
   assign mon.illegal_pulse = illegal_q;
   assign mon.lap_pulse     = lap_q;
   assign mon.err_count     = err_cnt;
   assign mon.lap_count     = lap_cnt;

   // A lap needs a correct transition and an error needs a wrong one, so they are exclusive.
   a_lap_err_exclusive: assert property (@(posedge clk) disable iff (reset)
      !(mon.lap_pulse && mon.err_pulse));

endmodule

// File: tb/tb_seq_monitor.sv
// Directed vector bench for seq_monitor with LOCK_CNT=3, ERR_W=2, LAP_W=8.
// Latency: checks each sample's response 1 ns after the edge that captured it.
// Backpressure: none; in_valid gating is exercised directly.
module tb_seq_monitor;

   logic clk;
   logic reset;

   seq_monitor_if #(.ERR_W(2), .LAP_W(8)) bus ();

   seq_monitor #(
      .LOCK_CNT (3),
      .ERR_W    (2),
      .LAP_W    (8)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .mon   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       vld;
      logic [3:0] code;
      logic       clr;
      logic       e_locked;
      logic       e_err;
      logic       e_ill;
      logic       e_lap;
      logic [1:0] e_errc;
      logic [7:0] e_lapc;
   } vec_t;

   vec_t vecs[$];
   int   n_cmp;
   int   n_fail;

   task automatic add(input logic v, input logic [3:0] c, input logic clr,
                      input logic l, input logic e, input logic i, input logic p,
                      input logic [1:0] ec, input logic [7:0] lc);
      vec_t t;
      t.vld = v; t.code = c; t.clr = clr;
      t.e_locked = l; t.e_err = e; t.e_ill = i; t.e_lap = p;
      t.e_errc = ec; t.e_lapc = lc;
      vecs.push_back(t);
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Drive one sample between edges, let the next rising edge take it, settle 1 ns.
   task automatic step(input logic v, input logic [3:0] c, input logic clr);
      @(negedge clk);
      bus.in_valid = v;
      bus.seq_in   = c;
      bus.clear    = clr;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [13:0] outs();
      return {bus.locked, bus.err_pulse, bus.illegal_pulse, bus.lap_pulse,
              bus.err_count, bus.lap_count};
   endfunction

   initial begin
      logic [3:0] lap_stream[19];
      logic [3:0] relock[4];
      n_cmp  = 0;
      n_fail = 0;

      // Lock and first lap on a clean stream.
      add(1,4'h0,0, 0,0,0,0, 2'd0,8'd0);
      add(1,4'h9,0, 0,0,0,0, 2'd0,8'd0);
      add(1,4'hA,0, 0,0,0,0, 2'd0,8'd0);
      add(1,4'hC,0, 1,0,0,0, 2'd0,8'd0);
      add(1,4'h7,0, 1,0,0,0, 2'd0,8'd0);
      add(1,4'hD,0, 1,0,0,0, 2'd0,8'd0);
      add(1,4'h4,0, 1,0,0,0, 2'd0,8'd0);
      add(1,4'h5,0, 1,0,0,0, 2'd0,8'd0);
      add(1,4'h6,0, 1,0,0,0, 2'd0,8'd0);
      add(1,4'h0,0, 1,0,0,1, 2'd0,8'd1);
      // Skip D while locked, then relock through TRACK (the 0 arrives in TRACK, so no lap).
      add(1,4'h9,0, 1,0,0,0, 2'd0,8'd1);
      add(1,4'hA,0, 1,0,0,0, 2'd0,8'd1);
      add(1,4'hC,0, 1,0,0,0, 2'd0,8'd1);
      add(1,4'h7,0, 1,0,0,0, 2'd0,8'd1);
      add(1,4'h4,0, 0,1,0,0, 2'd1,8'd1);
      add(1,4'h5,0, 0,0,0,0, 2'd1,8'd1);
      add(1,4'h6,0, 0,0,0,0, 2'd1,8'd1);
      add(1,4'h0,0, 1,0,0,0, 2'd1,8'd1);
      // Illegal code while locked: both pulses, one error, back to SEARCH.
      add(1,4'h9,0, 1,0,0,0, 2'd1,8'd1);
      add(1,4'hF,0, 0,1,1,0, 2'd2,8'd1);
      add(1,4'hA,0, 0,0,0,0, 2'd2,8'd1);
      add(1,4'hC,0, 0,0,0,0, 2'd2,8'd1);
      add(1,4'h7,0, 0,0,0,0, 2'd2,8'd1);
      add(1,4'hD,0, 1,0,0,0, 2'd2,8'd1);
      // Stalled counter with in_valid low is invisible; one valid repeat is an error.
      for (int k = 0; k < 5; k++) add(0,4'hC,0, 1,0,0,0, 2'd2,8'd1);
      add(1,4'hC,0, 0,1,0,0, 2'd3,8'd1);
      // Saturation at 3, then clear on the same edge as a further error.
      add(1,4'h7,0, 0,0,0,0, 2'd3,8'd1);
      add(1,4'hD,0, 0,0,0,0, 2'd3,8'd1);
      add(1,4'h4,0, 1,0,0,0, 2'd3,8'd1);
      add(1,4'h4,0, 0,1,0,0, 2'd3,8'd1);
      add(1,4'h5,0, 0,0,0,0, 2'd3,8'd1);
      add(1,4'h6,0, 0,0,0,0, 2'd3,8'd1);
      add(1,4'h0,0, 1,0,0,0, 2'd3,8'd1);
      add(1,4'h0,1, 0,1,0,0, 2'd0,8'd0);
      // Illegal code outside LOCKED: illegal pulse only.
      add(1,4'hE,0, 0,0,1,0, 2'd0,8'd0);

      reset        = 1'b1;
      bus.in_valid = 1'b1;
      bus.seq_in   = 4'h0;
      bus.clear    = 1'b0;
      @(posedge clk);
      #1;
      check("reset_outs", 32'(outs()), 32'd0);
      @(negedge clk);
      reset = 1'b0;

      for (int i = 0; i < vecs.size(); i++) begin
         step(vecs[i].vld, vecs[i].code, vecs[i].clr);
         check($sformatf("vec%0d", i), 32'(outs()),
               32'({vecs[i].e_locked, vecs[i].e_err, vecs[i].e_ill, vecs[i].e_lap,
                    vecs[i].e_errc, vecs[i].e_lapc}));
      end

      // Two full laps from SEARCH, then an asynchronous reset between edges.
      lap_stream = '{4'h0,4'h9,4'hA,4'hC,4'h7,4'hD,4'h4,4'h5,4'h6,4'h0,
                     4'h9,4'hA,4'hC,4'h7,4'hD,4'h4,4'h5,4'h6,4'h0};
      for (int i = 0; i < 19; i++) step(1'b1, lap_stream[i], 1'b0);
      check("two_laps_count", 32'(bus.lap_count), 32'd2);
      check("two_laps_locked", 32'(bus.locked), 32'd1);
      check("two_laps_pulse", 32'(bus.lap_pulse), 32'd1);

      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.seq_in   = 4'h9;
      #2;
      reset = 1'b1;
      #1;
      check("async_reset_outs", 32'(outs()), 32'd0);
      @(negedge clk);
      reset = 1'b0;

      // Starting on 9 (which follows the reset prev of 0) still costs one sample to leave SEARCH.
      relock = '{4'h9,4'hA,4'hC,4'h7};
      for (int i = 0; i < 4; i++) begin
         step(1'b1, relock[i], 1'b0);
         check($sformatf("relock%0d", i), 32'(bus.locked), (i == 3) ? 32'd1 : 32'd0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
